regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single regfile write port between two sources: the in-order pipeline writeback, which cannot be back-pressured, and the multi-cycle unit result (mul/div), which uses a valid/ready handshake.
- Multi-cycle results wait in a small pending buffer and drain when the pipeline is not writing.
- Provides a pending-register lookup so decode can forward or stall.
- Sits between the WB stage / multi-cycle unit and the regfile write port (rfwe/rfwa/rfwd).

Parameters:
DEPTH, 2, number of pending-buffer entries (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles the buffer may be denied the port before the pipeline is stalled

Ports:
cpu_clk_50M  in  1  system clock
cpu_rst  in  1  asynchronous, active-high reset
wb_we  in  1  pipeline writeback enable
wb_wa  in  reg_enum  pipeline writeback address
wb_wd  in  word_t  pipeline writeback data
wb_stall  out  1  port taken by buffer; pipeline must hold its WB stage
mc_valid  in  1  multi-cycle result valid
mc_ready  out  1  arbiter can accept multi-cycle result
mc_wa  in  reg_enum  multi-cycle result address
mc_wd  in  word_t  multi-cycle result data
rfwe  out  1  regfile write enable
rfwa  out  reg_enum  regfile write address
rfwd  out  word_t  regfile write data
chk_ra1  in  reg_enum  decode lookup address 1
pend_hit1  out  1  live buffered write pending to chk_ra1
pend_data1  out  word_t  data of youngest live match for chk_ra1
chk_ra2  in  reg_enum  decode lookup address 2
pend_hit2  out  1  same for chk_ra2
pend_data2  out  word_t  same for chk_ra2

Behaviour:
- Reset (async, cpu_rst=1):
  - Buffer empty; all entries not live; starve_cnt=0.
  - While reset is asserted: mc_ready=0, rfwe=0, wb_stall=0, pend_hit*=0, pend_data*=ZERO.
- Buffer: circular FIFO of {live, wa, wd}, head/tail pointers wrap mod DEPTH, count 0..DEPTH.
- Push (mc_valid && mc_ready):
  - mc_ready = (count != DEPTH), based on registered count only; no pass-through when full, even if a pop occurs the same cycle.
  - mc_wa==REG_ZERO: handshake completes, nothing enqueued.
  - An enqueued result is written to the regfile no earlier than the next cycle (min latency 1).
- Write-port grant each cycle, combinational outputs, priority order:
  1. Buffer non-empty and starve_cnt==STARVE_MAX: pop head; wb_stall=1; pipeline write not performed this cycle.
  2. wb_we && wb_wa!=REG_ZERO: rfwe=1, rfwa=wb_wa, rfwd=wb_wd; no pop.
  3. Buffer non-empty: pop head.
  4. Otherwise: rfwe=0.
- Pop: rfwe=head.live, rfwa=head.wa, rfwd=head.wd. A killed (not-live) head is still popped, with rfwe=0.
- rfwa/rfwd are don't-care when rfwe=0; drive ZERO.
- Kill rule (WAW ordering):
  - A performed pipeline write to address X clears live on every entry already in the buffer with wa==X.
  - An entry enqueued in the same cycle stays live (multi-cycle result treated as younger).
- starve_cnt:
  - Increments when the buffer is non-empty and not popped; saturates at STARVE_MAX.
  - Clears on any pop or when the buffer is empty.
- Lookup:
  - pend_hitN=1 iff chk_raN!=REG_ZERO and some live entry has wa==chk_raN.
  - pend_dataN = wd of the youngest such entry (closest to tail), else ZERO.
  - Purely combinational on registered buffer state; does not see same-cycle pushes.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset mid-operation discards all buffered results; no write is issued.

Decomposition:
- mip_cpu_pkg: reuse existing reg_enum, word_t, ZERO, REG_ZERO. Add the pend_entry_t struct {logic live; reg_enum wa; word_t wd;}.
- One sub-module: wb_pend_buf, holding FIFO storage, pointers, kill compare, and youngest-match lookup.
- The arbiter top holds the grant logic and starve_cnt.

Test Plan:
- Idle pipeline; push mc (wa=5, wd=32'h1234) -> next cycle rfwe=1, rfwa=5, rfwd=32'h1234; count returns to 0.
- wb_we=1 every cycle (wa=3); push two mc results -> mc_ready=0 after second; after 4 denied cycles wb_stall=1 and head written, pipeline write absent that cycle.
- Push mc wa=7 (wd=A); next cycle wb writes wa=7 (wd=B) -> entry killed; later pop gives rfwe=0; reg 7 ends as B.
- Push wa=9 wd=1 then wa=9 wd=2 while wb busy -> pend_hit1=1, pend_data1=2 for chk_ra1=9; chk_ra2=0 -> pend_hit2=0.
- mc push with wa=REG_ZERO -> mc_ready handshake completes, count stays 0, no rfwe.
- Assert cpu_rst with 2 entries buffered -> mc_ready=0, rfwe=0 immediately; after release count=0, no writes issued.

Source files
------------

// File: rtl/mip_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mip_cpu_pkg
// Description : Shared CPU types: register names, data word, pending-write entry.
// Revision    : 1.0 - initial release
// ============================================================================
package mip_cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t ZERO = 32'h0000_0000;

    typedef enum logic [4:0] {
        REG_ZERO, REG_AT, REG_V0, REG_V1,
        REG_A0,   REG_A1, REG_A2, REG_A3,
        REG_T0,   REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
        REG_S0,   REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_T8,   REG_T9, REG_K0, REG_K1,
        REG_GP,   REG_SP, REG_FP, REG_RA
    } reg_enum;

    typedef struct packed {
        logic    live;
        reg_enum wa;
        word_t   wd;
    } pend_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_pend_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_buf
// Description : Pending multi-cycle result FIFO with WAW kill and youngest-match lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_buf
    import mip_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  reg_enum     i_push_wa,
    input  word_t       i_push_wd,
    input  logic        i_pop,
    input  logic        i_kill,
    input  reg_enum     i_kill_wa,
    input  reg_enum     i_chk_ra1,
    input  reg_enum     i_chk_ra2,
    output logic        o_empty,
    output logic        o_full,
    output pend_entry_t o_head,
    output logic        o_hit1,
    output word_t       o_data1,
    output logic        o_hit2,
    output word_t       o_data2
);

    localparam int c_PTR_W = $clog2(DEPTH);

    pend_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_PTR_W:0]     r_count;

    pend_entry_t          w_look1;
    pend_entry_t          w_look2;

    // Scans oldest to youngest so the last match wins. Popped slots have live
    // cleared, so only occupied entries can ever match.
    function automatic pend_entry_t f_lookup(input reg_enum ra);
        pend_entry_t        res;
        logic [c_PTR_W-1:0] idx;
        res = '{live: 1'b0, wa: ra, wd: ZERO};
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + c_PTR_W'(k);
            if (ra != REG_ZERO && r_mem[idx].live && r_mem[idx].wa == ra) begin
                res.live = 1'b1;
                res.wd   = r_mem[idx].wd;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].wa == i_kill_wa) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (i_pop) begin
                r_mem[r_head].live <= 1'b0;
                r_head             <= r_head + c_PTR_W'(1);
            end
            // Written last so a same-cycle enqueue survives a matching kill.
            if (i_push) begin
                r_mem[r_tail] <= '{live: 1'b1, wa: i_push_wa, wd: i_push_wd};
                r_tail        <= r_tail + c_PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (c_PTR_W+1)'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - (c_PTR_W+1)'(1);
            end
        end
    end

    always_comb begin
        w_look1 = f_lookup(i_chk_ra1);
        w_look2 = f_lookup(i_chk_ra2);
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_head  = r_mem[r_head];
    assign o_hit1  = w_look1.live;
    assign o_data1 = w_look1.wd;
    assign o_hit2  = w_look2.live;
    assign o_data2 = w_look2.wd;

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Shares the regfile write port between pipeline WB and multi-cycle results.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter
    import mip_cpu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic    cpu_clk_50M,
    input  logic    cpu_rst,
    input  logic    wb_we,
    input  reg_enum wb_wa,
    input  word_t   wb_wd,
    output logic    wb_stall,
    input  logic    mc_valid,
    output logic    mc_ready,
    input  reg_enum mc_wa,
    input  word_t   mc_wd,
    output logic    rfwe,
    output reg_enum rfwa,
    output word_t   rfwd,
    input  reg_enum chk_ra1,
    output logic    pend_hit1,
    output word_t   pend_data1,
    input  reg_enum chk_ra2,
    output logic    pend_hit2,
    output word_t   pend_data2
);

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    logic [c_STARVE_W-1:0] r_starve;

    logic        w_empty;
    logic        w_full;
    pend_entry_t w_head;
    logic        w_starved;
    logic        w_wb_req;
    logic        w_wb_wr;
    logic        w_pop;
    logic        w_push;
    logic        w_hit1;
    logic        w_hit2;
    word_t       w_data1;
    word_t       w_data2;

    wb_pend_buf #(
        .DEPTH (DEPTH)
    ) u_pend_buf (
        .clk       (cpu_clk_50M),
        .rst       (cpu_rst),
        .i_push    (w_push),
        .i_push_wa (mc_wa),
        .i_push_wd (mc_wd),
        .i_pop     (w_pop),
        .i_kill    (w_wb_wr),
        .i_kill_wa (wb_wa),
        .i_chk_ra1 (chk_ra1),
        .i_chk_ra2 (chk_ra2),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_head    (w_head),
        .o_hit1    (w_hit1),
        .o_data1   (w_data1),
        .o_hit2    (w_hit2),
        .o_data2   (w_data2)
    );

    assign w_starved = !w_empty && (r_starve == c_STARVE_W'(STARVE_MAX));
    assign w_wb_req  = wb_we && (wb_wa != REG_ZERO);
    assign w_push    = mc_valid && mc_ready && (mc_wa != REG_ZERO);

    // Everything is gated by reset so a held pipeline write cannot leak through.
    always_comb begin
        mc_ready = 1'b0;
        wb_stall = 1'b0;
        w_wb_wr  = 1'b0;
        w_pop    = 1'b0;
        rfwe     = 1'b0;
        rfwa     = REG_ZERO;
        rfwd     = ZERO;
        if (!cpu_rst) begin
            mc_ready = !w_full;
            if (w_starved) begin
                w_pop    = 1'b1;
                wb_stall = 1'b1;
            end else if (w_wb_req) begin
                w_wb_wr = 1'b1;
            end else if (!w_empty) begin
                w_pop = 1'b1;
            end
            if (w_pop) begin
                if (w_head.live) begin
                    rfwe = 1'b1;
                    rfwa = w_head.wa;
                    rfwd = w_head.wd;
                end
            end else if (w_wb_wr) begin
                rfwe = 1'b1;
                rfwa = wb_wa;
                rfwd = wb_wd;
            end
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (r_starve != c_STARVE_W'(STARVE_MAX)) begin
            r_starve <= r_starve + c_STARVE_W'(1);
        end
    end

    assign pend_hit1  = !cpu_rst && w_hit1;
    assign pend_data1 = cpu_rst ? ZERO : w_data1;
    assign pend_hit2  = !cpu_rst && w_hit2;
    assign pend_data2 = cpu_rst ? ZERO : w_data2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed bench with a queue-based reference model for regfile_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;
    import mip_cpu_pkg::*;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic    cpu_clk_50M;
    logic    cpu_rst;
    logic    wb_we;
    reg_enum wb_wa;
    word_t   wb_wd;
    logic    wb_stall;
    logic    mc_valid;
    logic    mc_ready;
    reg_enum mc_wa;
    word_t   mc_wd;
    logic    rfwe;
    reg_enum rfwa;
    word_t   rfwd;
    reg_enum chk_ra1;
    logic    pend_hit1;
    word_t   pend_data1;
    reg_enum chk_ra2;
    logic    pend_hit2;
    word_t   pend_data2;

    regfile_wr_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .wb_we       (wb_we),
        .wb_wa       (wb_wa),
        .wb_wd       (wb_wd),
        .wb_stall    (wb_stall),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_wa       (mc_wa),
        .mc_wd       (mc_wd),
        .rfwe        (rfwe),
        .rfwa        (rfwa),
        .rfwd        (rfwd),
        .chk_ra1     (chk_ra1),
        .pend_hit1   (pend_hit1),
        .pend_data1  (pend_data1),
        .chk_ra2     (chk_ra2),
        .pend_hit2   (pend_hit2),
        .pend_data2  (pend_data2)
    );

    initial cpu_clk_50M = 1'b0;
    always #5 cpu_clk_50M = ~cpu_clk_50M;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic reg_enum R(input int n);
        return reg_enum'(n[4:0]);
    endfunction

    // Reference model: queue of pending results (index 0 = oldest) plus starve count.
    pend_entry_t q[$];
    int          starve = 0;
    word_t       rf_obs [32];

    function automatic void m_lookup(input reg_enum ra, output logic hit, output word_t d);
        hit = 1'b0;
        d   = ZERO;
        for (int i = int'(q.size()) - 1; i >= 0; i--) begin
            if (!hit && ra != REG_ZERO && q[i].live && q[i].wa == ra) begin
                hit = 1'b1;
                d   = q[i].wd;
            end
        end
    endfunction

    always @(negedge cpu_clk_50M) begin : compare
        logic    pop, wbw, stall, ready, h1, h2;
        word_t   d1, d2, e_wd;
        logic    e_we;
        reg_enum e_wa;
        if (cpu_rst) begin
            chk("cmp_rst_mc_ready", 32'(mc_ready), 32'd0);
            chk("cmp_rst_rfwe", 32'(rfwe), 32'd0);
            chk("cmp_rst_wb_stall", 32'(wb_stall), 32'd0);
            chk("cmp_rst_hit1", 32'(pend_hit1), 32'd0);
            chk("cmp_rst_hit2", 32'(pend_hit2), 32'd0);
            chk("cmp_rst_data1", pend_data1, ZERO);
            chk("cmp_rst_data2", pend_data2, ZERO);
            q.delete();
            starve = 0;
        end else begin
            ready = (q.size() < DEPTH);
            pop = 1'b0; wbw = 1'b0; stall = 1'b0;
            if (q.size() > 0 && starve == STARVE_MAX) begin
                pop = 1'b1; stall = 1'b1;
            end else if (wb_we && wb_wa != REG_ZERO) begin
                wbw = 1'b1;
            end else if (q.size() > 0) begin
                pop = 1'b1;
            end
            e_we = 1'b0; e_wa = REG_ZERO; e_wd = ZERO;
            if (pop) begin
                if (q[0].live) begin
                    e_we = 1'b1; e_wa = q[0].wa; e_wd = q[0].wd;
                end
            end else if (wbw) begin
                e_we = 1'b1; e_wa = wb_wa; e_wd = wb_wd;
            end
            m_lookup(chk_ra1, h1, d1);
            m_lookup(chk_ra2, h2, d2);
            chk("cmp_mc_ready", 32'(mc_ready), 32'(ready));
            chk("cmp_wb_stall", 32'(wb_stall), 32'(stall));
            chk("cmp_rfwe", 32'(rfwe), 32'(e_we));
            chk("cmp_rfwa", 32'(rfwa), 32'(e_wa));
            chk("cmp_rfwd", rfwd, e_wd);
            chk("cmp_hit1", 32'(pend_hit1), 32'(h1));
            chk("cmp_data1", pend_data1, d1);
            chk("cmp_hit2", 32'(pend_hit2), 32'(h2));
            chk("cmp_data2", pend_data2, d2);
            if (rfwe) rf_obs[rfwa] = rfwd;
            // Advance the model to the state after the coming clock edge.
            if (wbw) begin
                foreach (q[i]) if (q[i].wa == wb_wa) q[i].live = 1'b0;
            end
            if (q.size() == 0 || pop) starve = 0;
            else if (starve < STARVE_MAX) starve++;
            if (pop) void'(q.pop_front());
            if (mc_valid && ready && mc_wa != REG_ZERO)
                q.push_back('{live: 1'b1, wa: mc_wa, wd: mc_wd});
        end
    end

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    task automatic at_neg();
        @(negedge cpu_clk_50M);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_obs[i] = ZERO;
        cpu_rst = 1'b1; wb_we = 1'b1; wb_wa = R(3); wb_wd = 32'h33;
        mc_valid = 1'b1; mc_wa = R(5); mc_wd = 32'h1;
        chk_ra1 = R(0); chk_ra2 = R(0);

        // Outputs held quiet under reset even with live requests on the inputs.
        at_neg;
        chk("rst_mc_ready", 32'(mc_ready), 32'd0);
        chk("rst_rfwe", 32'(rfwe), 32'd0);
        chk("rst_wb_stall", 32'(wb_stall), 32'd0);
        tick;
        cpu_rst = 1'b0; wb_we = 1'b0; mc_valid = 1'b0;

        // Idle pipeline: single push drains the next cycle.
        mc_valid = 1'b1; mc_wa = R(5); mc_wd = 32'h1234;
        at_neg;
        chk("t1_ready", 32'(mc_ready), 32'd1);
        chk("t1_no_passthru", 32'(rfwe), 32'd0);
        tick;
        mc_valid = 1'b0;
        at_neg;
        chk("t1_rfwe", 32'(rfwe), 32'd1);
        chk("t1_rfwa", 32'(rfwa), 32'd5);
        chk("t1_rfwd", rfwd, 32'h1234);
        tick;
        at_neg;
        chk("t1_empty_rfwe", 32'(rfwe), 32'd0);
        tick;

        // Busy pipeline: fill buffer, then starvation forces a stall.
        wb_we = 1'b1; wb_wa = R(3); wb_wd = 32'h33;
        mc_valid = 1'b1; mc_wa = R(10); mc_wd = 32'hAA;
        at_neg;
        chk("t2_c0_rfwa", 32'(rfwa), 32'd3);
        tick;
        mc_wa = R(11); mc_wd = 32'hBB;
        at_neg;
        chk("t2_c1_ready", 32'(mc_ready), 32'd1);
        tick;
        mc_wa = R(12); mc_wd = 32'hCC;
        at_neg;
        chk("t2_full_ready", 32'(mc_ready), 32'd0);
        tick;
        mc_valid = 1'b0;
        at_neg;
        chk("t2_c3_stall", 32'(wb_stall), 32'd0);
        tick;
        at_neg;
        chk("t2_c4_stall", 32'(wb_stall), 32'd0);
        chk("t2_c4_rfwa", 32'(rfwa), 32'd3);
        tick;
        at_neg;
        chk("t2_c5_stall", 32'(wb_stall), 32'd1);
        chk("t2_c5_rfwa", 32'(rfwa), 32'd10);
        chk("t2_c5_rfwd", rfwd, 32'hAA);
        tick;
        at_neg;
        chk("t2_c6_stall", 32'(wb_stall), 32'd0);
        chk("t2_c6_rfwa", 32'(rfwa), 32'd3);
        tick;
        wb_we = 1'b0;
        at_neg;
        chk("t2_drain_rfwa", 32'(rfwa), 32'd11);
        chk("t2_drain_rfwd", rfwd, 32'hBB);
        tick;
        at_neg;
        chk("t2_idle_rfwe", 32'(rfwe), 32'd0);
        tick;

        // WAW kill: pipeline write to reg 7 supersedes the buffered result.
        mc_valid = 1'b1; mc_wa = R(7); mc_wd = 32'hA0A0_A0A0; chk_ra1 = R(7);
        at_neg;
        chk("t3_c0_rfwe", 32'(rfwe), 32'd0);
        tick;
        mc_valid = 1'b0; wb_we = 1'b1; wb_wa = R(7); wb_wd = 32'hB0B0_B0B0;
        at_neg;
        chk("t3_wb_rfwd", rfwd, 32'hB0B0_B0B0);
        chk("t3_hit_before", 32'(pend_hit1), 32'd1);
        chk("t3_data_before", pend_data1, 32'hA0A0_A0A0);
        tick;
        wb_we = 1'b0;
        at_neg;
        chk("t3_killed_rfwe", 32'(rfwe), 32'd0);
        chk("t3_killed_hit", 32'(pend_hit1), 32'd0);
        tick;
        at_neg;
        chk("t3_reg7", rf_obs[7], 32'hB0B0_B0B0);
        tick;

        // Push to REG_ZERO completes the handshake but enqueues nothing.
        chk_ra1 = R(0); mc_valid = 1'b1; mc_wa = R(0); mc_wd = 32'hFFFF;
        at_neg;
        chk("t5_ready", 32'(mc_ready), 32'd1);
        tick;
        mc_valid = 1'b0;
        at_neg;
        chk("t5_rfwe", 32'(rfwe), 32'd0);
        tick;

        // Two pending writes to reg 9: lookup returns the youngest.
        wb_we = 1'b1; wb_wa = R(3); wb_wd = 32'h44;
        mc_valid = 1'b1; mc_wa = R(9); mc_wd = 32'h1;
        at_neg;
        tick;
        mc_wd = 32'h2;
        at_neg;
        tick;
        mc_valid = 1'b0; chk_ra1 = R(9); chk_ra2 = R(0);
        at_neg;
        chk("t4_hit1", 32'(pend_hit1), 32'd1);
        chk("t4_data1", pend_data1, 32'h2);
        chk("t4_hit2", 32'(pend_hit2), 32'd0);
        chk("t4_full", 32'(mc_ready), 32'd0);

        // Asynchronous reset with two entries buffered.
        #2;
        cpu_rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(mc_ready), 32'd0);
        chk("t6_rst_rfwe", 32'(rfwe), 32'd0);
        chk("t6_rst_hit1", 32'(pend_hit1), 32'd0);
        tick;
        tick;
        cpu_rst = 1'b0; wb_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            at_neg;
            chk("t6_post_rfwe", 32'(rfwe), 32'd0);
            chk("t6_post_hit1", 32'(pend_hit1), 32'd0);
            chk("t6_post_ready", 32'(mc_ready), 32'd1);
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
